// File: rtl/multi_output_preimage_search.sv
// multi_output_preimage_search
//   Walks all 16 input vectors {A,B,C,D} and presents each one whose
//   three-output function value {F_alpha, F_beta, F_gamma} equals the
//   latched target. A match stays on the output until the consumer takes it.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a search (honoured only in IDLE)
//   abort        : cancel the current search (honoured only in SCAN)
//   target[2:0]  : {F_alpha, F_beta, F_gamma} pattern to invert
//   busy         : search in progress
//   match_valid  : match_abcd is a preimage of the latched target
//   match_ready  : consumer accepts the presented match
//   match_abcd   : candidate vector, A is the MSB
//   match_mask   : bit i set once vector i has been accepted
//   match_count  : number of accepted matches
//   done         : one-cycle pulse on normal completion
module multi_output_preimage_search (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  target,
  output logic        busy,
  output logic        match_valid,
  input  logic        match_ready,
  output logic [3:0]  match_abcd,
  output logic [15:0] match_mask,
  output logic [4:0]  match_count,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [2:0]  tgt;
  logic [2:0]  f_val;
  logic        accept;
  logic        advance;

  // Function under inversion, evaluated on the current candidate.
  always_comb begin
    logic a, b, c, d;
    a = idx[3];
    b = idx[2];
    c = idx[1];
    d = idx[0];
    f_val[2] = (~a & ~b & ~d) | (a & ~c & d) | (b & c & d);
    f_val[1] = (~a & ~b)      | (~a & ~c & d) | (b & c & d);
    f_val[0] = (a & ~b)       | (a & ~c & d)  | (b & c & d);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        if (abort)                          state_nxt = IDLE;
        else if (advance && idx == 4'd15)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; match_valid is derived from registered state only, so the
  // handshake never forms a combinational loop through match_ready.
  always_comb begin
    busy        = (state == SCAN);
    done        = (state == DONE);
    match_valid = busy && (f_val == tgt);
    match_abcd  = busy ? idx : '0;
    accept      = match_valid && match_ready;
    advance     = busy && (!match_valid || match_ready);
  end

  // Datapath. An acceptance coinciding with abort is still recorded;
  // idx saturates at 15 so it never wraps inside a search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      tgt         <= '0;
      match_mask  <= '0;
      match_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tgt         <= target;
            idx         <= '0;
            match_mask  <= '0;
            match_count <= '0;
          end
        end
        SCAN: begin
          if (accept) begin
            match_mask[idx] <= 1'b1;
            match_count     <= match_count + 5'd1;
          end
          if (advance && !abort && idx != 4'd15)
            idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_output_preimage_search.sv
module tb_multi_output_preimage_search;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [2:0]  target;
  logic        busy;
  logic        match_valid;
  logic        match_ready;
  logic [3:0]  match_abcd;
  logic [15:0] match_mask;
  logic [4:0]  match_count;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_output_preimage_search dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .target      (target),
    .busy        (busy),
    .match_valid (match_valid),
    .match_ready (match_ready),
    .match_abcd  (match_abcd),
    .match_mask  (match_mask),
    .match_count (match_count),
    .done        (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one search. stall_at/abort_at = -1 disables the feature.
  // order collects accepted vectors as nibbles, oldest in the high nibble.
  task automatic run_search(input logic [2:0] tgt, input int stall_at, input int stall_len,
                            input int abort_at, input bit hold_start,
                            output int edges, output logic [31:0] order, output bit saw_done);
    int stall_left;
    stall_left  = stall_len;
    edges       = 0;
    order       = '0;
    saw_done    = 1'b0;
    start       = 1'b1;
    target      = tgt;
    match_ready = 1'b1;
    abort       = 1'b0;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    target = ~tgt;
    while (edges < 60) begin
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (!busy) break;
      match_ready = 1'b1;
      abort       = 1'b0;
      if (match_valid && int'(match_abcd) == stall_at && stall_left > 0) begin
        match_ready = 1'b0;
        stall_left--;
        check_eq("stall_abcd", 32'(match_abcd), 32'(stall_at));
      end
      if (int'(match_abcd) == abort_at) abort = 1'b1;
      if (match_valid && match_ready) order = (order << 4) | 32'(match_abcd);
      @(posedge clk); #1;
      edges++;
    end
    start       = 1'b0;
    abort       = 1'b0;
    match_ready = 1'b1;
    if (edges >= 60) check_eq("timeout", 32'(edges), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"},  32'(busy),        32'd0);
    check_eq({tag, "_done"},  32'(done),        32'd0);
    check_eq({tag, "_valid"}, 32'(match_valid), 32'd0);
    check_eq({tag, "_abcd"},  32'(match_abcd),  32'd0);
    check_eq({tag, "_mask"},  32'(match_mask),  32'd0);
    check_eq({tag, "_count"}, 32'(match_count), 32'd0);
  endtask

  logic [2:0]  tv_tgt   [8] = '{3'b000, 3'b110, 3'b010, 3'b111, 3'b001, 3'b101, 3'b100, 3'b011};
  logic [15:0] tv_mask  [8] = '{16'h5050, 16'h0005, 16'h002A, 16'h8080, 16'h0D00, 16'h2200, 16'h0000, 16'h0000};
  logic [4:0]  tv_count [8] = '{5'd4, 5'd2, 5'd3, 5'd2, 5'd3, 5'd2, 5'd0, 5'd0};
  logic [31:0] tv_order [8] = '{32'h46CE, 32'h02, 32'h135, 32'h7F, 32'h8AB, 32'h9D, 32'h0, 32'h0};

  initial begin
    int          edges;
    logic [31:0] order;
    bit          saw_done;
    int          guard;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; target = 3'b000; match_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Every target, no stalls; search with index 1 keeps start high throughout.
    for (int i = 0; i < 8; i++) begin
      run_search(tv_tgt[i], -1, 0, -1, (i == 1), edges, order, saw_done);
      check_eq($sformatf("t%0d_done", i),  32'(saw_done),    32'd1);
      check_eq($sformatf("t%0d_edges", i), 32'(edges),       32'd16);
      check_eq($sformatf("t%0d_mask", i),  32'(match_mask),  32'(tv_mask[i]));
      check_eq($sformatf("t%0d_count", i), 32'(match_count), 32'(tv_count[i]));
      check_eq($sformatf("t%0d_order", i), order,            tv_order[i]);
      @(posedge clk); #1;
      check_eq($sformatf("t%0d_pulse", i), 32'(done),        32'd0);
      check_eq($sformatf("t%0d_idle", i),  32'(busy),        32'd0);
      check_eq($sformatf("t%0d_hold", i),  32'(match_mask),  32'(tv_mask[i]));
    end

    // Three-cycle stall on match 3 of target 010
    run_search(3'b010, 3, 3, -1, 1'b0, edges, order, saw_done);
    check_eq("stall_done",  32'(saw_done),    32'd1);
    check_eq("stall_edges", 32'(edges),       32'd19);
    check_eq("stall_mask",  32'(match_mask),  32'h002A);
    check_eq("stall_count", 32'(match_count), 32'd3);
    @(posedge clk); #1;

    // Abort at idx 8 on target 000
    run_search(3'b000, -1, 0, 8, 1'b0, edges, order, saw_done);
    check_eq("abort_nodone", 32'(saw_done),    32'd0);
    check_eq("abort_busy",   32'(busy),        32'd0);
    check_eq("abort_mask",   32'(match_mask),  32'h0050);
    check_eq("abort_count",  32'(match_count), 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("abort_quiet", 32'(done | busy), 32'd0);
    end
    run_search(3'b111, -1, 0, -1, 1'b0, edges, order, saw_done);
    check_eq("after_abort_mask", 32'(match_mask), 32'h8080);
    @(posedge clk); #1;

    // Abort coinciding with acceptance of vector 4
    run_search(3'b000, -1, 0, 4, 1'b0, edges, order, saw_done);
    check_eq("abacc_nodone", 32'(saw_done),    32'd0);
    check_eq("abacc_mask",   32'(match_mask),  32'h0010);
    check_eq("abacc_count",  32'(match_count), 32'd1);
    @(posedge clk); #1;

    // Reset asserted mid-scan at idx 5 of target 010
    start = 1'b1; target = 3'b010; match_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (match_abcd != 4'd5 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 40) check_eq("rst_reach5", 32'(guard), 32'd0);
    check_eq("rst_pre_count", 32'(match_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("midrst_wait", 32'(done | busy), 32'd0);
    end
    run_search(3'b010, -1, 0, -1, 1'b0, edges, order, saw_done);
    check_eq("midrst_done",  32'(saw_done),    32'd1);
    check_eq("midrst_mask",  32'(match_mask),  32'h002A);
    check_eq("midrst_count", 32'(match_count), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
